// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: priority stall masks, 3-cycle exception redirect (RUN->FREEZE->FLUSH).
// Optional stall/flush performance counters are built only when STALL_PERF_EN is defined.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam logic [31:0] EXC_ERET   = 32'h0000000e;
  localparam logic [31:0] EXC_VECTOR = 32'h00000020;

  typedef enum logic [1:0] {RUN, FREEZE, FLUSH} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] target;
  logic        exc_take;

  assign exc_take = (state == RUN) && (excepttype_i != 32'h0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      target <= 32'h0;
    end else begin
      state <= state_nxt;
      // EPC is captured in the detect cycle; later CP0 updates must not leak into the redirect.
      if (exc_take)
        target <= (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (exc_take) state_nxt = FREEZE;
      FREEZE:  state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0;
    case (state)
      RUN: begin
        if (exc_take)          stall = 6'b111111;
        else if (stallreq_mem) stall = 6'b011111;
        else if (stallreq_ex)  stall = 6'b001111;
        else if (stallreq_id)  stall = 6'b000111;
        else if (stallreq_if)  stall = 6'b000011;
        else                   stall = 6'b000000;
      end
      FREEZE: stall = 6'b111111;
      FLUSH: begin
        flush  = 1'b1;
        new_pc = target;
      end
      default: stall = 6'b000000;
    endcase
  end

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (stall[0] && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
      if (flush && !(&flush_cnt))    flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule
